// File: rtl/serial_subtractor_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int SERIAL_SUB_WIDTH_DEF = 8;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: diff = a - b - bin, bout = borrow out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bout
);

  assign diff = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor, LSB first, one full_subtractor cell.
// Define SERIAL_SUB_OVF_EN to build the signed-overflow flag; otherwise ovf is 0.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = SERIAL_SUB_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH) + 1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d, b_sh_q, b_sh_d, d_sh_q, d_sh_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             brw_q, brw_d, bout_q, bout_d;
  logic             cell_diff, cell_bout, accept, last_bit;
  logic [WIDTH:0]   d_cat;
  logic [WIDTH-1:0] d_next;

  full_subtractor u_fs (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .bin  (brw_q),
    .diff (cell_diff),
    .bout (cell_bout)
  );

  assign accept   = (state_q == IDLE) && start;
  assign last_bit = (state_q == RUN) && (cnt_q == CW'(WIDTH - 1));
  // Work word with the current cell bit shifted in; complete on the last bit.
  assign d_cat    = {cell_diff, d_sh_q};
  assign d_next   = d_cat[WIDTH:1];

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_bit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == DONE);
  end

  always_comb begin
    a_sh_d = a_sh_q;
    b_sh_d = b_sh_q;
    d_sh_d = d_sh_q;
    brw_d  = brw_q;
    cnt_d  = cnt_q;
    diff_d = diff_q;
    bout_d = bout_q;
    if (accept) begin
      a_sh_d = a;
      b_sh_d = b;
      d_sh_d = '0;
      brw_d  = bin;
      cnt_d  = '0;
    end else if (state_q == RUN) begin
      a_sh_d = a_sh_q >> 1;
      b_sh_d = b_sh_q >> 1;
      d_sh_d = d_next;
      brw_d  = cell_bout;
      cnt_d  = cnt_q + 1'b1;
      if (last_bit) begin
        diff_d = d_next;
        bout_d = cell_bout;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sh_q <= '0;
      b_sh_q <= '0;
      d_sh_q <= '0;
      brw_q  <= 1'b0;
      cnt_q  <= '0;
      diff_q <= '0;
      bout_q <= 1'b0;
    end else begin
      a_sh_q <= a_sh_d;
      b_sh_q <= b_sh_d;
      d_sh_q <= d_sh_d;
      brw_q  <= brw_d;
      cnt_q  <= cnt_d;
      diff_q <= diff_d;
      bout_q <= bout_d;
    end
  end

  assign diff = diff_q;
  assign bout = bout_q;

`ifdef SERIAL_SUB_OVF_EN
  // Operand MSBs are shifted out during RUN, so keep a copy for the flag.
  logic a_msb_q, a_msb_d, b_msb_q, b_msb_d, ovf_q, ovf_d;

  always_comb begin
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    ovf_d   = ovf_q;
    if (accept) begin
      a_msb_d = a[WIDTH-1];
      b_msb_d = b[WIDTH-1];
    end else if (last_bit) begin
      ovf_d = (a_msb_q != b_msb_q) && (d_next[WIDTH-1] != a_msb_q);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      ovf_q   <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (WIDTH=8), optional SERIAL_SUB_OVF_EN.
module tb_serial_subtractor;

  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
  } res_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         bin = 1'b0;
  logic         busy, done, bout, ovf;
  logic [W-1:0] diff;

  int   n_chk = 0;
  int   n_pass = 0;
  res_t exp_q[$];

  serial_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bin(bin),
    .busy(busy), .done(done), .diff(diff), .bout(bout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
  endtask

  function automatic res_t model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi);
    res_t       r;
    logic [W:0] full;
    full   = {1'b0, av} - {1'b0, bv} - {{W{1'b0}}, bi};
    r.diff = full[W-1:0];
    r.bout = full[W];
`ifdef SERIAL_SUB_OVF_EN
    r.ovf  = (av[W-1] != bv[W-1]) && (r.diff[W-1] != av[W-1]);
`else
    r.ovf  = 1'b0;
`endif
    return r;
  endfunction

  // Drives one operation from IDLE and checks framing, result hold and result.
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi,
                        input bit hold_start);
    res_t prev, e;
    bit   got;
    int   n;
    prev = '{diff: diff, bout: bout, ovf: ovf};
    @(negedge clk);
    a = av; b = bv; bin = bi; start = 1'b1;
    exp_q.push_back(model(av, bv, bi));
    @(posedge clk);
    got = 0;
    n = 0;
    for (int c = 0; c < 14 && !got; c++) begin
      @(negedge clk);
      n++;
      if (hold_start) begin
        if (c == 0) begin a = 8'h11; b = 8'h22; bin = 1'b1; end
        if (c == 4) start = 1'b0;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        got = 1;
        e = exp_q.pop_front();
        chk("done_latency", n, W + 1);
        chk("busy_at_done", busy, 0);
        chk("diff", diff, e.diff);
        chk("bout", bout, e.bout);
        chk("ovf", ovf, e.ovf);
      end else if (n <= W) begin
        chk("busy_run", busy, 1);
        chk("diff_held", {diff, bout, ovf}, prev);
      end
    end
    if (!got) begin
      chk("done_timeout", 0, 1);
      void'(exp_q.pop_front());
    end
    start = 1'b0;
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("idle_after_done", busy, 0);
  endtask

  initial begin
    int pulses;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_diff", diff, 0);
    chk("rst_bout", bout, 0);
    chk("rst_ovf", ovf, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(8'h5A, 8'h3C, 1'b0, 0);
    run_op(8'h00, 8'h01, 1'b0, 0);
    run_op(8'hFF, 8'hFF, 1'b1, 0);
    run_op(8'h80, 8'h01, 1'b0, 0);
    run_op(8'h7F, 8'h80, 1'b0, 0);
    // start held with new operands during RUN must not disturb the result
    run_op(8'h5A, 8'h3C, 1'b0, 1);
    chk("ignored_start", diff, 8'h1E);
    run_op(8'h11, 8'h22, 1'b0, 0);

    // abort in the 4th RUN cycle
    @(negedge clk);
    a = 8'hC3; b = 8'h05; bin = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_diff", diff, 0);
    chk("abort_bout", bout, 0);
    chk("abort_ovf", ovf, 0);
    pulses = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done || busy) pulses++;
    end
    chk("abort_no_done", pulses, 0);
    run_op(8'h10, 8'h01, 1'b0, 0);

    for (int i = 0; i < 6; i++)
      run_op(W'($urandom), W'($urandom), 1'($urandom), 0);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
